pc_sequencer: RTL and testbench

Program-counter and fetch sequencer for the processor core. It drives instruction-memory reads and holds each fetched word until the execute stage accepts it. At acceptance it takes the 13-bit control word for that instruction, already decoded from its opcode, together with the branch-condition flags, and computes the next PC. It is the producer of the opcode field and the consumer of the flow-control bits (`ctrl[12:6]`) of the control word.

---
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: fetches one instruction word, holds it until execute accepts it, then computes the next PC.
// Optional `PC_SEQ_HALT_EN` adds a halt input and a terminal HALT state.
module pc_sequencer #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       insn,
  output logic              insn_valid,
  input  logic              insn_ready,
  input  logic [12:0]       ctrl,
  input  logic              cond_ne,
  input  logic              cond_lt,
  input  logic              rstatus_nz,
  input  logic [31:0]       rd_value,
`ifdef PC_SEQ_HALT_EN
  input  logic              halt,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_pc
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
`ifdef PC_SEQ_HALT_EN
    , ST_HALT = 2'd3
`endif
  } state_t;

  state_t            state, state_nxt;
  logic              load_insn;
  logic              accept;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] next_pc;

  // Flow-control decode of the control word.
  logic is_setx, is_bex, is_blt, is_jr, is_jal, is_bne, is_j;
  assign {is_setx, is_bex, is_blt, is_jr, is_jal, is_bne, is_j} = ctrl[12:6];

  // Setx, the low control bits and the upper Jr bits have no effect on the PC.
  logic unused_ok;
  assign unused_ok = ^{is_setx, ctrl[5:0], rd_value[31:ADDR_W]};

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    load_insn = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_START: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          load_insn = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (insn_ready) begin
          accept    = 1'b1;
          state_nxt = ST_FETCH;
`ifdef PC_SEQ_HALT_EN
          if (halt) state_nxt = ST_HALT;
`endif
        end
      end
`ifdef PC_SEQ_HALT_EN
      ST_HALT:  state_nxt = ST_HALT;
`endif
      default:  state_nxt = ST_START;
    endcase
  end

  // Arithmetic wraps naturally at ADDR_W bits; the 17-bit offset is sign-extended or truncated to fit.
  assign seq_pc = pc + ADDR_W'(1);
  assign br_pc  = seq_pc + ADDR_W'($signed(insn[16:0]));

  always_comb begin
    next_pc = seq_pc;
    if (is_jr)                    next_pc = rd_value[ADDR_W-1:0];
    else if (is_j || is_jal)      next_pc = insn[ADDR_W-1:0];
    else if (is_bex && rstatus_nz) next_pc = insn[ADDR_W-1:0];
    else if (is_bne && cond_ne)   next_pc = br_pc;
    else if (is_blt && cond_lt)   next_pc = br_pc;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_START;
      pc    <= '0;
      insn  <= '0;
    end else begin
      state <= state_nxt;
      if (load_insn) insn <= imem_rdata;
      if (accept)    pc   <= next_pc;
    end
  end

  assign imem_req   = (state == ST_FETCH);
  assign insn_valid = (state == ST_ISSUE);
  assign imem_addr  = pc;
  assign link_pc    = seq_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed instruction vectors, a transaction-level PC model and per-cycle output comparison.
module tb_pc_sequencer;

  localparam int ADDR_W = 12;
  localparam int PC_MOD = 1 << ADDR_W;

  localparam logic [12:0] C_SETX = 13'h1000;
  localparam logic [12:0] C_BEX  = 13'h0800;
  localparam logic [12:0] C_BLT  = 13'h0400;
  localparam logic [12:0] C_JR   = 13'h0200;
  localparam logic [12:0] C_JAL  = 13'h0100;
  localparam logic [12:0] C_BNE  = 13'h0080;
  localparam logic [12:0] C_J    = 13'h0040;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic [31:0]       insn;
  logic              insn_valid;
  logic              insn_ready;
  logic [12:0]       ctrl;
  logic              cond_ne;
  logic              cond_lt;
  logic              rstatus_nz;
  logic [31:0]       rd_value;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link_pc;
`ifdef PC_SEQ_HALT_EN
  logic              halt;
`endif

  pc_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .insn       (insn),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .ctrl       (ctrl),
    .cond_ne    (cond_ne),
    .cond_lt    (cond_lt),
    .rstatus_nz (rstatus_nz),
    .rd_value   (rd_value),
`ifdef PC_SEQ_HALT_EN
    .halt       (halt),
`endif
    .pc         (pc),
    .link_pc    (link_pc)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: where the block is in its fetch/hold cycle and what the PC must be.
  bit          m_started  = 1'b0;
  bit          m_fetching = 1'b0;
  bit          m_holding  = 1'b0;
  int          m_pc       = 0;
  logic [31:0] m_insn     = 32'h0;

  function automatic int wrap(input int v);
    return ((v % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  function automatic int model_next();
    int off;
    int target;
    off    = int'(m_insn[16:0]);
    if (m_insn[16]) off -= 131072;
    target = int'(m_insn[ADDR_W-1:0]);
    if (ctrl & C_JR)                       return int'(rd_value[ADDR_W-1:0]);
    if (ctrl & (C_J | C_JAL))              return target;
    if ((ctrl & C_BEX) != 0 && rstatus_nz) return target;
    if ((ctrl & C_BNE) != 0 && cond_ne)    return wrap(m_pc + 1 + off);
    if ((ctrl & C_BLT) != 0 && cond_lt)    return wrap(m_pc + 1 + off);
    return wrap(m_pc + 1);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_started  = 1'b0;
      m_fetching = 1'b0;
      m_holding  = 1'b0;
      m_pc       = 0;
      m_insn     = 32'h0;
    end else if (!m_started) begin
      m_started  = 1'b1;
      m_fetching = 1'b1;
    end else if (m_fetching) begin
      if (imem_ready) begin
        m_insn     = imem_rdata;
        m_fetching = 1'b0;
        m_holding  = 1'b1;
      end
    end else if (m_holding && insn_ready) begin
      m_pc      = model_next();
      m_holding = 1'b0;
`ifdef PC_SEQ_HALT_EN
      m_fetching = !halt;
`else
      m_fetching = 1'b1;
`endif
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("imem_req",   32'(imem_req),   32'(m_fetching));
      check("insn_valid", 32'(insn_valid), 32'(m_holding));
      check("pc",         32'(pc),         32'(m_pc));
      check("imem_addr",  32'(imem_addr),  32'(m_pc));
      check("link_pc",    32'(link_pc),    32'(wrap(m_pc + 1)));
      check("insn",       insn,            m_insn);
    end
  end

  task automatic wait_fetch();
    int guard = 0;
    while (imem_req !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) check("fetch_timeout", 32'(imem_req), 32'h1);
  endtask

  // One instruction: optional memory wait, optional execute stall, then acceptance with the given control/flags.
  task automatic run_insn(input logic [31:0] word, input logic [12:0] c, input logic ne, input logic lt,
                          input logic rz, input logic [31:0] rdv, input int mem_wait, input int stall);
    logic [ADDR_W-1:0] addr0;
    wait_fetch();
    addr0 = imem_addr;
    for (int i = 0; i < mem_wait; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clock);
      check("wait_addr", 32'(imem_addr), 32'(addr0));
      check("wait_req",  32'(imem_req),  32'h1);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clock);
    imem_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      insn_ready = 1'b0;
      imem_rdata = $urandom;
      ctrl       = 13'($urandom);
      cond_ne    = 1'($urandom);
      @(negedge clock);
      check("stall_insn", insn,           word);
      check("stall_req",  32'(imem_req),  32'h0);
      check("stall_pc",   32'(pc),        32'(addr0));
    end
    insn_ready = 1'b1;
    ctrl       = c;
    cond_ne    = ne;
    cond_lt    = lt;
    rstatus_nz = rz;
    rd_value   = rdv;
    @(negedge clock);
    insn_ready = 1'b0;
    ctrl       = 13'($urandom);
    cond_ne    = 1'($urandom);
    cond_lt    = 1'($urandom);
    rstatus_nz = 1'($urandom);
    rd_value   = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0;
    insn_ready = 1'b1;
    ctrl       = 13'h0;
    cond_ne    = 1'b0;
    cond_lt    = 1'b0;
    rstatus_nz = 1'b0;
    rd_value   = 32'h0;
`ifdef PC_SEQ_HALT_EN
    halt       = 1'b0;
`endif
    #1 cmp_en = 1'b1;

    // Zero-wait throughput after reset release.
    repeat (2) @(negedge clock);
    check("rst_pc",      32'(pc),      32'h0);
    check("rst_link_pc", 32'(link_pc), 32'h1);
    reset_n = 1'b1;
    check("rel_req", 32'(imem_req), 32'h0);
    for (int i = 1; i <= 7; i++) begin
      imem_rdata = 32'(i) << 20;
      @(negedge clock);
      check("tp_req", 32'(imem_req), 32'(i % 2));
      if (i % 2 == 1) check("tp_addr", 32'(imem_addr), 32'((i - 1) / 2));
    end
    imem_ready = 1'b0;
    insn_ready = 1'b0;

    // Bne taken and not taken at pc=5.
    run_insn(32'h0000_0005, C_J | 13'h2A, 0, 0, 0, 32'h0, 0, 0);
    check("j_to_5", 32'(pc), 32'h005);
    run_insn(32'h0001_FFFD, C_BNE, 1, 0, 0, 32'h0, 0, 0);
    check("bne_taken", 32'(imem_addr), 32'h003);
    run_insn(32'h0000_0005, C_J, 0, 0, 0, 32'h0, 0, 0);
    run_insn(32'h0001_FFFD, C_BNE, 0, 0, 0, 32'h0, 0, 0);
    check("bne_not_taken", 32'(imem_addr), 32'h006);

    // Jal with truncated target, then Jr priority over J.
    run_insn(32'h0000_000A, C_J, 0, 0, 0, 32'h0, 0, 0);
    run_insn(32'hABCD_F123, C_JAL, 1, 1, 1, 32'h0, 0, 0);
    check("jal_pc",   32'(pc),      32'h123);
    check("jal_link", 32'(link_pc), 32'h124);
    run_insn(32'h0000_0777, C_JR | C_J, 0, 0, 0, 32'hDEAD_0040, 0, 0);
    check("jr_prio", 32'(pc), 32'h040);

    // Execute stall and memory wait.
    run_insn(32'h1234_5678, 13'h0, 1, 1, 1, 32'h0, 0, 4);
    check("stall_accept", 32'(pc), 32'h041);
    run_insn(32'h0000_0100, 13'h0, 0, 0, 0, 32'h0, 3, 0);
    check("wait_accept", 32'(pc), 32'h042);

    // Wrap at the top of the address space and branch arithmetic.
    run_insn(32'h0000_0FFF, C_J, 0, 0, 0, 32'h0, 0, 0);
    check("top_link", 32'(link_pc), 32'h000);
    run_insn(32'h0000_0000, 13'h0, 0, 0, 0, 32'h0, 0, 0);
    check("wrap_pc", 32'(pc), 32'h000);
    run_insn(32'h0000_0200, C_BEX, 0, 0, 0, 32'h0, 0, 0);
    check("bex_not_taken", 32'(pc), 32'h001);
    run_insn(32'h0000_0200, C_BEX, 0, 0, 1, 32'h0, 0, 0);
    check("bex_taken", 32'(pc), 32'h200);
    run_insn(32'h0000_0005, C_BLT, 0, 1, 0, 32'h0, 1, 1);
    check("blt_taken", 32'(pc), 32'h206);
    run_insn(32'h0000_0005, C_BLT, 0, 0, 0, 32'h0, 0, 0);
    check("blt_not_taken", 32'(pc), 32'h207);
    run_insn(32'h0001_FFFF, C_BNE, 1, 0, 0, 32'h0, 0, 0);
    check("bne_self", 32'(pc), 32'h207);
    run_insn(32'h0000_0010, C_SETX, 1, 1, 1, 32'h0, 0, 0);
    check("setx", 32'(pc), 32'h208);
    run_insn(32'h0001_FFFE, C_BNE | C_BLT, 0, 1, 0, 32'h0, 0, 0);
    check("bne_miss_blt_hit", 32'(pc), 32'h207);
    run_insn(32'h0000_0001, C_J, 0, 0, 0, 32'h0, 0, 0);
    run_insn(32'h0001_FFFB, C_BNE, 1, 0, 0, 32'h0, 0, 0);
    check("bne_wrap_down", 32'(pc), 32'hFFD);

    // Reset mid-fetch with a memory response in the same cycle.
    wait_fetch();
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    #2 reset_n = 1'b0;
    #1;
    check("rf_req",   32'(imem_req),   32'h0);
    check("rf_valid", 32'(insn_valid), 32'h0);
    check("rf_pc",    32'(pc),         32'h0);
    check("rf_link",  32'(link_pc),    32'h1);
    check("rf_insn",  insn,            32'h0);
    @(negedge clock);
    imem_ready = 1'b0;
    reset_n    = 1'b1;
    @(negedge clock);
    check("rf_after_insn", insn, 32'h0);

    // Reset mid-issue.
    wait_fetch();
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    @(negedge clock);
    imem_ready = 1'b0;
    check("ri_valid_before", 32'(insn_valid), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("ri_valid", 32'(insn_valid), 32'h0);
    check("ri_insn",  insn,            32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    run_insn(32'h0000_0033, C_J, 0, 0, 0, 32'h0, 0, 0);
    check("post_reset_j", 32'(pc), 32'h033);

`ifdef PC_SEQ_HALT_EN
    halt = 1'b1;
    run_insn(32'h0000_0055, C_J, 0, 0, 0, 32'h0, 2, 1);
    check("halt_pc", 32'(pc), 32'h055);
    imem_ready = 1'b1;
    insn_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("halt_req",   32'(imem_req),   32'h0);
      check("halt_valid", 32'(insn_valid), 32'h0);
    end
    halt = 1'b0;
`endif

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
